txn_sequencer: RTL and testbench
================================

TXN_SEQUENCER -- requirements
Module: txn_sequencer

Interface
REQ-001 Clock and reset: one clock; reset is asynchronous and active-low. Ports clk (in, 1, rising-edge clock) and rst_b (in, 1, async active-low reset).
REQ-002 start  in  1  one-cycle request to begin a transaction; sampled only in IDLE.
REQ-003 is_read  in  1  1 = IN transaction, 0 = OUT transaction; captured with start.
REQ-004 addr  in  7  device address; endp  in  4  endpoint; both captured with start.
REQ-005 data_in  in  64  OUT payload, captured with start; data_out  out  64  IN payload.
REQ-006 done  out  1  one-cycle pulse at transaction end; success  out  1  result, valid while done=1.
REQ-007 pkt_in  out  99  packet to datapath encoder; pkt_in_avail  out  1  one-cycle launch strobe.
REQ-008 encoder_ready  in  1  encoder accepts a launch; nrzi_avail  in  1  transmit line busy.
REQ-009 pkt_out  in  99  received packet; pkt_out_avail  in  1  received-packet strobe; data_good  in  1  CRC check passed; decoder_ready  in  1  decoder idle.
REQ-010 re  out  1  receive enable to datapath line interface.

Function
REQ-011 Packet layout SHALL be: bits[7:0] PID; token bits[14:8] addr, [18:15] endp; data bits[71:8] payload; all unused bits 0.
REQ-012 PIDs SHALL be: OUT 8'hE1, IN 8'h69, DATA0 8'hC3, ACK 8'hD2, NAK 8'h5A.
REQ-013 States SHALL be IDLE, TOKEN, DATA_TX, WAIT_HS, WAIT_DATA, SEND_ACK, FINISH.
REQ-014 IDLE: start=1 captures inputs, clears attempt counter to 1, goes to TOKEN; start outside IDLE SHALL be ignored.
REQ-015 Every launch: pkt_in_avail pulses exactly one cycle, only when encoder_ready=1 and nrzi_avail=0; pkt_in held stable from launch until transmit complete.
REQ-016 Transmit complete = nrzi_avail observed 1 then 0 after the launch cycle.
REQ-017 TOKEN: launch OUT or IN token; on complete go to DATA_TX (OUT) or WAIT_DATA (IN).
REQ-018 DATA_TX: launch DATA0 with captured payload; on complete go to WAIT_HS.
REQ-019 re SHALL be 1 exactly in WAIT_HS and WAIT_DATA, and 0 in all other states.
REQ-020 WAIT_HS: pkt_out_avail with PID ACK -> FINISH, success=1; NAK, other PID, or timeout -> attempt failure.
REQ-021 WAIT_DATA: pkt_out_avail, data_good=1, PID DATA0 -> load data_out from pkt_out[71:8], go to SEND_ACK; NAK, data_good=0, other PID, or timeout -> attempt failure.
REQ-022 SEND_ACK: launch ACK packet; on complete go to FINISH with success=1.
REQ-023 Timeout counter: 8-bit, cleared on entry to WAIT_HS/WAIT_DATA, increments each cycle; expiry when value 255 is reached without a packet.
REQ-024 pkt_out_avail in the same cycle as expiry SHALL be processed as a packet, not a timeout.
REQ-025 Attempt failure: attempt counter <8 -> increment, return to TOKEN; counter =8 -> FINISH with success=0.
REQ-026 FINISH: done=1 for one cycle, success valid, next state IDLE; start is not accepted in FINISH.
REQ-027 data_out SHALL change only on REQ-021 load; retained across OUT transactions.
REQ-028 Total attempts per transaction SHALL not exceed 8; no launch is issued in IDLE or FINISH.

Reset
REQ-029 rst_b=0 SHALL immediately force state IDLE, and set done, success, pkt_in_avail and re to 0; pkt_in, data_out, timeout and attempt counters to 0.
REQ-030 Reset mid-transaction SHALL abandon it without a done pulse; the first start after release is served normally.

Verification
REQ-031 OUT, addr=7'h05, endp=4'h2, data_in=64'hDEADBEEF_01234567, device ACKs -> tokens E1/C3 launched once each, done=1 with success=1.
REQ-032 OUT, device NAKs every attempt -> exactly 8 OUT tokens launched, done=1 with success=0.
REQ-033 IN, device returns DATA0 with data_good=1 and payload 64'h0123_4567_89AB_CDEF -> data_out equals that payload, ACK launched, success=1.
REQ-034 IN, first DATA0 has data_good=0, second is good -> 2 IN tokens, one ACK, success=1.
REQ-035 WAIT_HS with no response -> retry after 255 cycles, re=0 between attempts; ACK on cycle 255 is accepted as a packet.
REQ-036 rst_b pulsed low during DATA_TX -> all outputs 0 same cycle, no done; a new start completes normally.

Source files
------------

// File: rtl/txn_sequencer.sv
// txn_sequencer
//   Host-side transaction sequencer. Captures a request (IN or OUT, device
//   address, endpoint, OUT payload), launches token / data / handshake
//   packets to the datapath encoder, waits for the device response with a
//   255-cycle timeout and retries up to 8 attempts per transaction.
//
// Ports
//   clk, rst_b         rising-edge clock, asynchronous active-low reset
//   start              one-cycle request, honoured only in IDLE
//   is_read            1 = IN transaction, 0 = OUT transaction
//   addr, endp         device address (7b) and endpoint (4b)
//   data_in            OUT payload (64b)
//   data_out           last good IN payload (64b)
//   done, success      one-cycle completion pulse and its result
//   pkt_in             packet presented to the encoder (99b)
//   pkt_in_avail       one-cycle launch strobe
//   encoder_ready      encoder can accept a launch
//   nrzi_avail         transmit line busy
//   pkt_out            received packet (99b), qualified by pkt_out_avail
//   data_good          CRC of received packet is good
//   decoder_ready      decoder idle (informational, not needed here)
//   re                 receive enable, high while waiting for a response
module txn_sequencer (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        start,
  input  logic        is_read,
  input  logic [6:0]  addr,
  input  logic [3:0]  endp,
  input  logic [63:0] data_in,
  output logic [63:0] data_out,
  output logic        done,
  output logic        success,
  output logic [98:0] pkt_in,
  output logic        pkt_in_avail,
  input  logic        encoder_ready,
  input  logic        nrzi_avail,
  input  logic [98:0] pkt_out,
  input  logic        pkt_out_avail,
  input  logic        data_good,
  input  logic        decoder_ready,
  output logic        re
);

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_ACK   = 8'hD2;

  localparam logic [3:0] MAX_ATTEMPTS = 4'd8;
  localparam logic [7:0] TMO_LAST     = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    TOKEN,
    DATA_TX,
    WAIT_HS,
    WAIT_DATA,
    SEND_ACK,
    FINISH
  } state_t;

  state_t      state;
  logic        cap_read;
  logic [6:0]  cap_addr;
  logic [3:0]  cap_endp;
  logic [63:0] cap_payload;
  logic        launched;    // a packet is on its way out, waiting for completion
  logic        seen_busy;   // line has gone busy since the launch
  logic [7:0]  tmo_cnt;
  logic [3:0]  attempt;

  function automatic logic [98:0] token_pkt(input logic [7:0] pid,
                                            input logic [6:0] a,
                                            input logic [3:0] e);
    return {80'd0, e, a, pid};
  endfunction

  function automatic logic [98:0] data_pkt(input logic [7:0]  pid,
                                           input logic [63:0] payload);
    return {27'd0, payload, pid};
  endfunction

  function automatic logic [98:0] hs_pkt(input logic [7:0] pid);
    return {91'd0, pid};
  endfunction

  logic        launch_state;
  logic        can_launch;
  logic        tx_done;
  logic        in_wait;
  logic        pkt_accept;
  logic        wait_fail;
  logic        wait_ok;
  logic [98:0] next_pkt;

  always_comb begin
    next_pkt     = '0;
    launch_state = 1'b0;
    case (state)
      TOKEN: begin
        launch_state = 1'b1;
        next_pkt     = token_pkt(cap_read ? PID_IN : PID_OUT, cap_addr, cap_endp);
      end
      DATA_TX: begin
        launch_state = 1'b1;
        next_pkt     = data_pkt(PID_DATA0, cap_payload);
      end
      SEND_ACK: begin
        launch_state = 1'b1;
        next_pkt     = hs_pkt(PID_ACK);
      end
      default: ;
    endcase

    can_launch = !launched && encoder_ready && !nrzi_avail;
    // Completion is the busy-to-idle transition of the line after launch.
    tx_done    = launched && seen_busy && !nrzi_avail;

    in_wait    = (state == WAIT_HS) || (state == WAIT_DATA);
    // NAK and any unexpected PID simply fail to match here.
    pkt_accept = (state == WAIT_HS) ? (pkt_out[7:0] == PID_ACK)
                                    : (data_good && (pkt_out[7:0] == PID_DATA0));
    wait_ok    = in_wait && pkt_out_avail && pkt_accept;
    // A packet arriving on the last timeout cycle wins over the timeout.
    wait_fail  = in_wait && ((pkt_out_avail && !pkt_accept) ||
                             (!pkt_out_avail && (tmo_cnt == TMO_LAST)));
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= IDLE;
      done         <= 1'b0;
      success      <= 1'b0;
      pkt_in_avail <= 1'b0;
      re           <= 1'b0;
      pkt_in       <= '0;
      data_out     <= '0;
      tmo_cnt      <= '0;
      attempt      <= '0;
      launched     <= 1'b0;
      seen_busy    <= 1'b0;
      cap_read     <= 1'b0;
      cap_addr     <= '0;
      cap_endp     <= '0;
      cap_payload  <= '0;
    end else begin
      pkt_in_avail <= 1'b0;
      done         <= 1'b0;

      if (launch_state) begin
        if (can_launch) begin
          pkt_in       <= next_pkt;
          pkt_in_avail <= 1'b1;
          launched     <= 1'b1;
          seen_busy    <= 1'b0;
        end else if (launched && nrzi_avail) begin
          seen_busy <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          success <= 1'b0;
          if (start) begin
            cap_read    <= is_read;
            cap_addr    <= addr;
            cap_endp    <= endp;
            cap_payload <= data_in;
            attempt     <= 4'd1;
            launched    <= 1'b0;
            seen_busy   <= 1'b0;
            state       <= TOKEN;
          end
        end

        TOKEN: begin
          if (tx_done) begin
            launched <= 1'b0;
            if (cap_read) begin
              state   <= WAIT_DATA;
              re      <= 1'b1;
              tmo_cnt <= '0;
            end else begin
              state <= DATA_TX;
            end
          end
        end

        DATA_TX: begin
          if (tx_done) begin
            launched <= 1'b0;
            state    <= WAIT_HS;
            re       <= 1'b1;
            tmo_cnt  <= '0;
          end
        end

        WAIT_HS, WAIT_DATA: begin
          if (wait_fail) begin
            re <= 1'b0;
            if (attempt == MAX_ATTEMPTS) begin
              state   <= FINISH;
              done    <= 1'b1;
              success <= 1'b0;
            end else begin
              attempt <= attempt + 4'd1;
              state   <= TOKEN;
            end
          end else if (wait_ok) begin
            re <= 1'b0;
            if (state == WAIT_HS) begin
              state   <= FINISH;
              done    <= 1'b1;
              success <= 1'b1;
            end else begin
              data_out <= pkt_out[71:8];
              state    <= SEND_ACK;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        SEND_ACK: begin
          if (tx_done) begin
            launched <= 1'b0;
            state    <= FINISH;
            done     <= 1'b1;
            success  <= 1'b1;
          end
        end

        FINISH: begin
          success <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Inputs carried by the interface but not needed by the sequencer.
  logic unused_inputs;
  assign unused_inputs = ^{decoder_ready, pkt_out[98:72]};

endmodule

// File: tb/tb_txn_sequencer.sv
// tb_txn_sequencer
//   Bench for txn_sequencer: an encoder/line model, a device responder
//   driven from per-attempt scenario tables, and a transaction-level
//   reference model that predicts the launched packets, result and data_out.
module tb_txn_sequencer;

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_BAD   = 8'h4B;

  localparam int R_ACK     = 0;
  localparam int R_NAK     = 1;
  localparam int R_OTHER   = 2;
  localparam int R_TIMEOUT = 3;
  localparam int R_DGOOD   = 4;
  localparam int R_DBAD    = 5;

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic        start = 1'b0;
  logic        is_read = 1'b0;
  logic [6:0]  addr = '0;
  logic [3:0]  endp = '0;
  logic [63:0] data_in = '0;
  logic [63:0] data_out;
  logic        done;
  logic        success;
  logic [98:0] pkt_in;
  logic        pkt_in_avail;
  logic        encoder_ready;
  logic        nrzi_avail;
  logic [98:0] pkt_out;
  logic        pkt_out_avail;
  logic        data_good;
  logic        decoder_ready;
  logic        re;

  txn_sequencer dut (
    .clk(clk), .rst_b(rst_b), .start(start), .is_read(is_read),
    .addr(addr), .endp(endp), .data_in(data_in), .data_out(data_out),
    .done(done), .success(success), .pkt_in(pkt_in),
    .pkt_in_avail(pkt_in_avail), .encoder_ready(encoder_ready),
    .nrzi_avail(nrzi_avail), .pkt_out(pkt_out),
    .pkt_out_avail(pkt_out_avail), .data_good(data_good),
    .decoder_ready(decoder_ready), .re(re)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int          scen_r [8];
  int          scen_d [8];
  logic [63:0] scen_pay = '0;
  int          scen_gen = 0;

  logic [98:0] launch_q [$];
  logic [98:0] exp_q [$];
  logic [63:0] mdl_dout = '0;
  int          txn_base = 0;

  int   viol_line = 0;
  int   viol_mon  = 0;
  int   done_cnt  = 0;
  int   last_to_len = 0;

  task automatic check_val(input string tag, input logic [127:0] got,
                           input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [98:0] make_resp(input int r, input logic [63:0] pay);
    case (r)
      R_ACK:           return {91'd0, PID_ACK};
      R_NAK:           return {91'd0, PID_NAK};
      R_DGOOD, R_DBAD: return {27'd0, pay, PID_DATA0};
      default:         return {91'd0, PID_BAD};
    endcase
  endfunction

  // Encoder / NRZI line model: accepts a launch, stays quiet a little,
  // goes busy for a few cycles, then idles again.
  initial begin
    int dly;
    int len;
    logic active;
    logic [98:0] held;
    encoder_ready = 1'b0;
    nrzi_avail    = 1'b0;
    active = 1'b0;
    dly = 0;
    len = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        active = 1'b0;
        nrzi_avail = 1'b0;
        encoder_ready = 1'b0;
      end else begin
        if (done && pkt_in_avail) viol_line++;
        if (pkt_in_avail) begin
          if (!encoder_ready || nrzi_avail || active || re) viol_line++;
          launch_q.push_back(pkt_in);
          held = pkt_in;
          active = 1'b1;
          dly = $urandom_range(0, 2);
          len = $urandom_range(1, 5);
          nrzi_avail = 1'b0;
          encoder_ready = 1'b0;
        end else if (active) begin
          if (pkt_in !== held) viol_line++;
          if (dly > 0) dly--;
          else if (len > 0) begin
            nrzi_avail = 1'b1;
            len--;
          end else begin
            nrzi_avail = 1'b0;
            active = 1'b0;
          end
          encoder_ready = 1'b0;
        end else begin
          encoder_ready = ($urandom_range(0, 3) != 0);
        end
      end
    end
  end

  // Device responder: one scenario entry per receive window.
  initial begin
    int r;
    int d;
    int cnt;
    int idx;
    int my_gen;
    pkt_out_avail = 1'b0;
    pkt_out = '0;
    data_good = 1'b0;
    decoder_ready = 1'b1;
    idx = 0;
    my_gen = 0;
    forever begin
      @(negedge clk);
      if (scen_gen != my_gen) begin
        my_gen = scen_gen;
        idx = 0;
      end
      if (rst_b && re && idx < 8) begin
        r = scen_r[idx];
        d = scen_d[idx];
        idx++;
        if (r == R_TIMEOUT) begin
          cnt = 0;
          while (re && cnt < 400) begin
            cnt++;
            @(negedge clk);
          end
          last_to_len = cnt;
        end else begin
          repeat (d) @(negedge clk);
          pkt_out = make_resp(r, scen_pay);
          data_good = (r == R_DGOOD);
          pkt_out_avail = 1'b1;
          @(negedge clk);
          pkt_out_avail = 1'b0;
          data_good = 1'b0;
          pkt_out = '0;
          cnt = 0;
          while (re && cnt < 50) begin
            cnt++;
            @(negedge clk);
          end
        end
      end
    end
  end

  // Completion monitor.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (prev || re) viol_mon++;
      end
      prev = done;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic fill_scen(input int r, input int d);
    for (int k = 0; k < 8; k++) begin
      scen_r[k] = r;
      scen_d[k] = d;
    end
    scen_gen++;
  endtask

  // Transaction-level prediction: each attempt sends the token (plus DATA0
  // for OUT); the attempt succeeds on ACK (OUT) or good DATA0 (IN, which
  // adds the host ACK and updates data_out). At most 8 attempts.
  task automatic model_txn(input logic rd, input logic [6:0] a,
                           input logic [3:0] e, input logic [63:0] d,
                           output logic succ);
    exp_q.delete();
    succ = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back({80'd0, e, a, (rd ? PID_IN : PID_OUT)});
      if (!rd) begin
        exp_q.push_back({27'd0, d, PID_DATA0});
        if (scen_r[k] == R_ACK) begin
          succ = 1'b1;
          break;
        end
      end else if (scen_r[k] == R_DGOOD) begin
        exp_q.push_back({91'd0, PID_ACK});
        mdl_dout = scen_pay;
        succ = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_txn(input string name, input logic rd, input logic [6:0] a,
                         input logic [3:0] e, input logic [63:0] d,
                         input bit poke_start);
    logic exp_s;
    logic got_s;
    int   cyc;
    int   dbase;
    int   nl;
    model_txn(rd, a, e, d, exp_s);
    txn_base = launch_q.size();
    dbase = done_cnt;
    got_s = 1'b0;
    @(negedge clk);
    is_read = rd; addr = a; endp = e; data_in = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    is_read = 1'($urandom); addr = 7'($urandom); endp = 4'($urandom);
    data_in = {$urandom(), $urandom()};
    if (poke_start) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    cyc = 0;
    while (!done && cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    check_val($sformatf("%s:done_seen", name), (cyc < 6000), 1'b1);
    got_s = success;
    // start during FINISH must not begin a new transaction
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    nl = launch_q.size() - txn_base;
    check_val($sformatf("%s:success", name), got_s, exp_s);
    check_val($sformatf("%s:done_cnt", name), done_cnt - dbase, 1);
    check_val($sformatf("%s:n_launch", name), nl, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < nl; i++)
      check_val($sformatf("%s:pkt%0d", name, i), launch_q[txn_base + i], exp_q[i]);
    check_val($sformatf("%s:data_out", name), data_out, mdl_dout);
  endtask

  initial begin
    int cyc;
    int ntok;
    int dbase;
    logic rd;

    // Asynchronous reset: outputs clear before any clock edge.
    #1 rst_b = 1'b0;
    #1;
    check_val("rst:pkt_in_avail", pkt_in_avail, 1'b0);
    check_val("rst:done", done, 1'b0);
    check_val("rst:success", success, 1'b0);
    check_val("rst:re", re, 1'b0);
    check_val("rst:pkt_in", pkt_in, 99'd0);
    check_val("rst:data_out", data_out, 64'd0);
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    check_val("idle:no_launch", launch_q.size(), 0);

    // OUT, ACK on first attempt
    fill_scen(R_NAK, 5);
    scen_r[0] = R_ACK;
    run_txn("out_ack", 1'b0, 7'h05, 4'h2, 64'hDEADBEEF_01234567, 1'b0);

    // OUT, NAK every attempt
    fill_scen(R_NAK, 3);
    run_txn("out_nak", 1'b0, 7'h11, 4'h7, 64'h1111_2222_3333_4444, 1'b0);
    ntok = 0;
    for (int i = txn_base; i < launch_q.size(); i++)
      if (launch_q[i][7:0] == PID_OUT) ntok++;
    check_val("out_nak:tokens", ntok, 8);

    // IN, good DATA0
    fill_scen(R_DGOOD, 4);
    scen_pay = 64'h0123_4567_89AB_CDEF;
    run_txn("in_good", 1'b1, 7'h22, 4'h1, 64'h0, 1'b0);

    // IN, first DATA0 has bad CRC, second good
    fill_scen(R_DGOOD, 2);
    scen_r[0] = R_DBAD;
    scen_pay = 64'hFEDC_BA98_7654_3210;
    run_txn("in_bad1", 1'b1, 7'h7F, 4'hF, 64'h0, 1'b0);

    // OUT, no handshake then ACK on the last timeout cycle
    fill_scen(R_NAK, 3);
    scen_r[0] = R_TIMEOUT;
    scen_r[1] = R_ACK;
    scen_d[1] = 255;
    run_txn("tmo_ack255", 1'b0, 7'h33, 4'h4, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0);
    check_val("tmo:re_window", last_to_len, 256);

    // Reset during DATA_TX
    fill_scen(R_ACK, 2);
    txn_base = launch_q.size();
    dbase = done_cnt;
    @(negedge clk);
    is_read = 1'b0; addr = 7'h44; endp = 4'h3; data_in = 64'h5555_6666_7777_8888;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (launch_q.size() < txn_base + 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_val("rstmid:reach_data", (cyc < 200), 1'b1);
    #2 rst_b = 1'b0;
    #1;
    check_val("rstmid:pkt_in_avail", pkt_in_avail, 1'b0);
    check_val("rstmid:pkt_in", pkt_in, 99'd0);
    check_val("rstmid:re", re, 1'b0);
    check_val("rstmid:done", done, 1'b0);
    check_val("rstmid:data_out", data_out, 64'd0);
    mdl_dout = '0;
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    repeat (20) @(negedge clk);
    check_val("rstmid:no_done", done_cnt - dbase, 0);
    fill_scen(R_DGOOD, 6);
    scen_pay = 64'hCAFE_F00D_1234_ABCD;
    run_txn("after_rst", 1'b1, 7'h09, 4'h8, 64'h0, 1'b0);

    // Randomized transactions
    for (int t = 0; t < 20; t++) begin
      int p;
      rd = 1'($urandom);
      for (int k = 0; k < 8; k++) begin
        p = $urandom_range(0, 99);
        if (rd)
          scen_r[k] = (p < 35) ? R_DGOOD : (p < 60) ? R_DBAD :
                      (p < 80) ? R_NAK : (p < 92) ? R_OTHER : R_TIMEOUT;
        else
          scen_r[k] = (p < 35) ? R_ACK : (p < 75) ? R_NAK :
                      (p < 92) ? R_OTHER : R_TIMEOUT;
        scen_d[k] = ($urandom_range(0, 15) == 0) ? 255 : $urandom_range(0, 30);
      end
      scen_gen++;
      scen_pay = {$urandom(), $urandom()};
      run_txn($sformatf("rnd%0d", t), rd, 7'($urandom), 4'($urandom),
              {$urandom(), $urandom()}, 1'b1);
    end

    check_val("line_proto", viol_line, 0);
    check_val("done_proto", viol_mon, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
